otp_array_model: RTL and testbench
==================================

# otp_array_model

- Synthesizable responder model of the one-time-programmable bit array driven by the OTP controller FSM.
- Storage: A rows × B columns of fuse bits.
- It decodes the controller's PL/BL/WLN/WLP/PRG lines, applies programming pulse-width rules, returns sensed column data after a fixed latency, and reports `writing_successful` back to the controller.
- It sits at the far end of the controller's array interface, both in the top-level FPGA build and in the controller testbench.

## Interface
- `A`, 2, number of rows; data width per column.
- `B`, 2, number of columns.
- `PROG_CYCLES`, 4, consecutive cycles of a valid program condition needed to blow the selected fuses (≥1).
- `READ_LAT`, 2, cycles from the first valid read condition to `sense_valid` (≥1).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PL`  in  2*B  program-line pairs; column c uses `PL[2c+1:2c]`.
- `BL`  in  B  bit-line column select; must be one-hot when active.
- `WLN`  in  A  read word-line enables, one per row.
- `WLP`  in  A  program word-line enables, one per row.
- `PRG`  in  1  program-mode strobe.
- `writing_successful`  out  1  one-cycle pulse when a program operation completes.
- `sense_data`  out  A  sensed column data; held until the next read completes.
- `sense_valid`  out  1  one-cycle pulse when `sense_data` updates.
- `protocol_err`  out  1  sticky illegal-drive flag (see Configuration).

## Operation
- **Fuse array.**
  - A×B bit register, all 0 at configuration/simulation start.
  - `reset` does NOT clear fuses: they are nonvolatile.
  - Fuses only ever go 0→1.
- **Column index.** c = position of the single 1 in `BL`.
- **Program condition (PC).**
  - `PRG`=1, `BL` one-hot, `PL[2c+1:2c]`=2'b11, all other PL bits 0, `WLP`≠0.
- **Read condition (RC).**
  - `PRG`=0, `BL` one-hot, `PL`=0, `WLP`=0, `WLN`≠0.
- **States:** S_IDLE, S_PROG, S_PROG_HOLD, S_READ.
  - S_IDLE, PC true: capture c and `WLP` into `sel_col`/`sel_row`, set `cnt`=1, go to S_PROG.
  - S_IDLE, RC true: capture c and `WLN`, set `lat`=1, go to S_READ.
  - S_IDLE, otherwise: stay.
  - S_PROG, PC true with unchanged c and `WLP`: `cnt`++.
  - S_PROG, when `cnt` reaches `PROG_CYCLES`: OR `sel_row` into column `sel_col`, pulse `writing_successful` next cycle, go to S_PROG_HOLD.
  - S_PROG, PC false or selection changed before that: abort without modifying fuses, go to S_IDLE. If PC is true with a new selection, restart as a fresh pulse (`cnt`=1, stay in S_PROG).
  - S_PROG_HOLD: wait for `PRG`=0, then go to S_IDLE. No second pulse or second write while `PRG` stays high.
  - S_READ, RC true with unchanged c and `WLN`: `lat`++.
  - S_READ, when `lat` reaches `READ_LAT`: `sense_data[r]` = fuse[r][c] & captured `WLN[r]`, pulse `sense_valid`, go to S_IDLE.
  - S_READ, RC dropped or selection changed: abort, `sense_data` unchanged, go to S_IDLE.
- PC and RC are mutually exclusive by construction.
- **Counter widths:** `$clog2(PROG_CYCLES+1)` and `$clog2(READ_LAT+1)`, saturating, never wrapping.
- **Reprogramming** an already-1 fuse is legal: success still pulses and the value stays 1.

## Timing
- **Reset values:** `writing_successful`=0, `sense_data`=0, `sense_valid`=0, `protocol_err`=0; state S_IDLE; counters 0.
- **Program latency:** `writing_successful` rises on the edge after the PROG_CYCLES-th consecutive PC cycle. The fuse update is visible on that same edge.
- **Read latency:** `sense_valid` and `sense_data` update on the edge after the READ_LAT-th consecutive RC cycle.
- **Reset mid-operation:**
  - Program aborted with no fuse change, even if `cnt`=PROG_CYCLES-1.
  - A pending read produces no `sense_valid`.
- All outputs are registered.

## Configuration
- Macro: `OTP_MODEL_PROTOCOL_CHECK_EN`.
- **Defined:** `protocol_err` sets, and stays set until `reset`, on any cycle where any of the following holds:
  - `PRG`=1 and `BL` is not one-hot;
  - `PRG`=1 and `WLP`=0;
  - `PRG`=1 and a PL pair other than column c's is nonzero;
  - `WLP`≠0 and `WLN`≠0 at the same time;
  - `PL`≠0 while `PRG`=0.
- **Not defined:** `protocol_err` is tied 0, and the same illegal cycles are silently treated as neither PC nor RC.

## Structure
- Package `otp_pkg`: state enum `otp_model_state_t` (4 states), the default-dimension localparams, and the `PL` pair code constant `PL_PROG`=2'b11.
- One sub-module `otp_onehot_decode`:
  - Parameter `N`, input vector, outputs `valid` (exactly one bit set) and `idx` (`$clog2(N)` bits).
  - Instantiated once on `BL`.

## Test plan
- **Program:** A=2, B=2, PROG_CYCLES=4. Drive PC for 4 cycles with `BL`=2'b10, `PL`=4'b1100, `WLP`=2'b01.
  - Expect `writing_successful` for exactly 1 cycle; fuse[0][1]=1.
- **Readback:** then RC for 2 cycles with `BL`=2'b10, `WLN`=2'b11.
  - Expect `sense_valid` 1 cycle with `sense_data`=2'b01. Column 0 reads 2'b00.
- **Short pulse:** PC for 3 cycles, then `PRG`=0.
  - Expect no success pulse; a later read of that column returns 2'b00.
- **Held `PRG`:** hold `PRG`=1 for 10 cycles after success.
  - Expect a single `writing_successful` pulse; re-entry only after `PRG`=0.
- **Reset mid-operation:** assert `reset` at cnt=3 of a program.
  - Expect no fuse change and outputs 0. Previously programmed fuses survive the reset (read still returns 2'b01).
- **Protocol check** (macro defined): `PRG`=1 with `BL`=2'b11.
  - Expect `protocol_err`=1, held until `reset`, and no fuse change.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared types and constants for the OTP fuse-array responder model.
package otp_pkg;

  // Default array geometry and timing
  localparam int OTP_A_DEFAULT           = 2;
  localparam int OTP_B_DEFAULT           = 2;
  localparam int OTP_PROG_CYCLES_DEFAULT = 4;
  localparam int OTP_READ_LAT_DEFAULT    = 2;

  // Code a column's PL pair must carry while that column is being programmed
  localparam logic [1:0] PL_PROG = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PROG      = 2'd1,
    S_PROG_HOLD = 2'd2,
    S_READ      = 2'd3
  } otp_model_state_t;

endpackage

// File: rtl/otp_onehot_decode.sv
// One-hot checker and binary index encoder for a select vector.
module otp_onehot_decode
  import otp_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic seen;
  logic multi;

  // Scan for set bits: valid only when exactly one is set
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = IW'(i);
      end
    end
    valid = seen & ~multi;
  end

endmodule

// File: rtl/otp_array_model.sv
// Responder model of the OTP fuse array seen by the OTP controller.
// Optional build macro: OTP_MODEL_PROTOCOL_CHECK_EN enables the sticky
// protocol_err flag; otherwise protocol_err is tied low.
module otp_array_model
  import otp_pkg::*;
#(
  parameter int A           = OTP_A_DEFAULT,
  parameter int B           = OTP_B_DEFAULT,
  parameter int PROG_CYCLES = OTP_PROG_CYCLES_DEFAULT,
  parameter int READ_LAT    = OTP_READ_LAT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*B-1:0] PL,
  input  logic [B-1:0]   BL,
  input  logic [A-1:0]   WLN,
  input  logic [A-1:0]   WLP,
  input  logic           PRG,
  output logic           writing_successful,
  output logic [A-1:0]   sense_data,
  output logic           sense_valid,
  output logic           protocol_err
);

  localparam int IW = (B > 1) ? $clog2(B) : 1;
  localparam int PW = 2 * B;
  localparam int CW = $clog2(PROG_CYCLES + 1);
  localparam int LW = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PROG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PROG_CYCLES);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);

  // NOTE: the fuse array has no reset branch on purpose; fuses are
  // nonvolatile, so only the declaration value (all blank) initialises them.
  logic [B-1:0][A-1:0] fuse = '0;

  otp_model_state_t state, state_n;
  logic [IW-1:0] sel_col, sel_col_n, col_idx, wr_col;
  logic [A-1:0]  sel_row, sel_row_n, wr_row, sd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] lat, lat_n;
  logic          ws_n, sv_n, do_write, start_prog, start_read;
  logic          bl_valid, illegal, pc, rc, same_sel;
  logic [PW-1:0] pl_sel;

  otp_onehot_decode #(.N(B)) u_bl_decode (
    .vec  (BL),
    .valid(bl_valid),
    .idx  (col_idx)
  );

  // Expected PL pattern for the selected column, and the legal-condition decode
  assign pl_sel   = PW'(PL_PROG) << {col_idx, 1'b0};
  assign illegal  = (PRG && !bl_valid) || (PRG && WLP == '0) ||
                    (PRG && (PL & ~pl_sel) != '0) ||
                    (WLP != '0 && WLN != '0) || (!PRG && PL != '0);
  assign pc       = PRG && bl_valid && PL == pl_sel && WLP != '0 && !illegal;
  assign rc       = !PRG && bl_valid && PL == '0 && WLP == '0 && WLN != '0 && !illegal;
  assign same_sel = (col_idx == sel_col) && ((pc ? WLP : WLN) == sel_row);

  // Next-state decode for the program/read sequencer
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_n    = state;
    sel_col_n  = sel_col;
    sel_row_n  = sel_row;
    cnt_n      = cnt;
    lat_n      = lat;
    ws_n       = 1'b0;
    sv_n       = 1'b0;
    sd_n       = sense_data;
    do_write   = 1'b0;
    wr_col     = sel_col;
    wr_row     = sel_row;
    start_prog = 1'b0;
    start_read = 1'b0;
    case (state)
      S_IDLE: begin
        if (pc)      start_prog = 1'b1;
        else if (rc) start_read = 1'b1;
      end
      S_PROG: begin
        if (pc && same_sel) begin
          if (cnt >= CNT_LAST) begin
            do_write = 1'b1;
            ws_n     = 1'b1;
            cnt_n    = CNT_MAX;
            state_n  = S_PROG_HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (pc) begin
          start_prog = 1'b1;
        end else begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      S_PROG_HOLD: begin
        if (!PRG) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      S_READ: begin
        if (rc && same_sel) begin
          if (lat >= LAT_LAST) begin
            sv_n    = 1'b1;
            sd_n    = fuse[sel_col] & sel_row;
            lat_n   = '0;
            state_n = S_IDLE;
          end else begin
            lat_n = lat + 1'b1;
          end
        end else begin
          lat_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A fresh pulse captures the selection; one-cycle configs complete at once
    if (start_prog) begin
      sel_col_n = col_idx;
      sel_row_n = WLP;
      cnt_n     = CW'(1);
      state_n   = S_PROG;
      if (PROG_CYCLES == 1) begin
        do_write = 1'b1;
        wr_col   = col_idx;
        wr_row   = WLP;
        ws_n     = 1'b1;
        state_n  = S_PROG_HOLD;
      end
    end
    if (start_read) begin
      sel_col_n = col_idx;
      sel_row_n = WLN;
      lat_n     = LW'(1);
      state_n   = S_READ;
      if (READ_LAT == 1) begin
        sv_n    = 1'b1;
        sd_n    = fuse[col_idx] & WLN;
        lat_n   = '0;
        state_n = S_IDLE;
      end
    end
  end

  // Sequencer registers and registered outputs
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state              <= S_IDLE;
      sel_col            <= '0;
      sel_row            <= '0;
      cnt                <= '0;
      lat                <= '0;
      writing_successful <= 1'b0;
      sense_valid        <= 1'b0;
      sense_data         <= '0;
    end else begin
      state              <= state_n;
      sel_col            <= sel_col_n;
      sel_row            <= sel_row_n;
      cnt                <= cnt_n;
      lat                <= lat_n;
      writing_successful <= ws_n;
      sense_valid        <= sv_n;
      sense_data         <= sd_n;
    end
  end

  // Fuse blow: bits only ever go 0->1, and never while reset is asserted
  always_ff @(posedge clk) begin
    if (!reset && do_write) fuse[wr_col] <= fuse[wr_col] | wr_row;
  end

`ifdef OTP_MODEL_PROTOCOL_CHECK_EN
  // Sticky illegal-drive flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)        protocol_err <= 1'b0;
    else if (illegal) protocol_err <= 1'b1;
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_otp_array_model.sv
// Scoreboard bench for otp_array_model (A=2, B=2, PROG_CYCLES=4, READ_LAT=2).
// Stimulus pushes expected pulses; a negedge monitor pops and compares them.
module tb_otp_array_model;

  localparam int A           = 2;
  localparam int B           = 2;
  localparam int PROG_CYCLES = 4;
  localparam int READ_LAT    = 2;
  localparam int K_WS        = 1;
  localparam int K_RD        = 2;

  typedef struct {
    int         kind;
    logic [1:0] data;
    int         cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [2*B-1:0] PL = '0;
  logic [B-1:0]   BL = '0;
  logic [A-1:0]   WLN = '0;
  logic [A-1:0]   WLP = '0;
  logic           PRG = 1'b0;
  logic           writing_successful;
  logic [A-1:0]   sense_data;
  logic           sense_valid;
  logic           protocol_err;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  otp_array_model #(
    .A(A), .B(B), .PROG_CYCLES(PROG_CYCLES), .READ_LAT(READ_LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .PL                (PL),
    .BL                (BL),
    .WLN               (WLN),
    .WLP               (WLP),
    .PRG               (PRG),
    .writing_successful(writing_successful),
    .sense_data        (sense_data),
    .sense_valid       (sense_valid),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input logic [1:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_idle();
    PRG = 1'b0; BL = '0; PL = '0; WLN = '0; WLP = '0;
  endtask

  task automatic prog(input logic [1:0] bl, input logic [3:0] pl, input logic [1:0] wlp,
                      input int n, input bit ok);
    PRG = 1'b1; BL = bl; PL = pl; WLP = wlp; WLN = '0;
    for (int i = 0; i < n; i++) begin
      if (ok && i == PROG_CYCLES - 1) push_exp(K_WS, 2'b00);
      step(1);
    end
  endtask

  task automatic read(input logic [1:0] bl, input logic [1:0] wln, input int n,
                      input bit ok, input logic [1:0] data);
    PRG = 1'b0; BL = bl; PL = '0; WLP = '0; WLN = wln;
    for (int i = 0; i < n; i++) begin
      if (ok && i == READ_LAT - 1) push_exp(K_RD, data);
      step(1);
    end
  endtask

  task automatic rd_check(input logic [1:0] bl, input logic [1:0] data);
    drive_idle();
    step(1);
    read(bl, 2'b11, READ_LAT, 1'b1, data);
    drive_idle();
    step(1);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!reset && (writing_successful || sense_valid)) begin
      k = writing_successful ? K_WS : K_RD;
      check("ws_sv_exclusive", {31'd0, writing_successful & sense_valid}, 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", k, 0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        if (e.kind == K_RD) check("sense_data", {30'd0, sense_data}, {30'd0, e.data});
      end
    end
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    step(2);
    check("rst_ws", {31'd0, writing_successful}, 0);
    check("rst_sv", {31'd0, sense_valid}, 0);
    check("rst_sd", {30'd0, sense_data}, 0);
    check("rst_perr", {31'd0, protocol_err}, 0);
    reset = 1'b0;
    step(1);

    // Program fuse[row0][col1], then read both columns
    prog(2'b10, 4'b1100, 2'b01, PROG_CYCLES, 1'b1);
    drive_idle();
    step(1);
    rd_check(2'b10, 2'b01);
    rd_check(2'b01, 2'b00);

    // Short pulse on column 0 row 1: no success, no fuse change
    prog(2'b01, 4'b0011, 2'b10, PROG_CYCLES - 1, 1'b0);
    drive_idle();
    step(1);
    rd_check(2'b01, 2'b00);

    // Read aborted after one cycle leaves sense_data untouched
    rd_check(2'b10, 2'b01);
    read(2'b10, 2'b11, 1, 1'b0, 2'b00);
    drive_idle();
    step(2);
    check("sd_held_after_abort", {30'd0, sense_data}, 32'h1);

    // Reset at cnt=3 of a program on column 0 row 0
    prog(2'b01, 4'b0011, 2'b01, PROG_CYCLES - 1, 1'b0);
    reset = 1'b1;
    step(1);
    check("midrst_ws", {31'd0, writing_successful}, 0);
    check("midrst_sv", {31'd0, sense_valid}, 0);
    check("midrst_sd", {30'd0, sense_data}, 0);
    reset = 1'b0;
    drive_idle();
    step(1);
    rd_check(2'b10, 2'b01);
    rd_check(2'b01, 2'b00);

    // PRG held high well past success: exactly one pulse
    prog(2'b01, 4'b0011, 2'b10, PROG_CYCLES + 10, 1'b1);
    drive_idle();
    step(1);
    rd_check(2'b01, 2'b10);

    // Re-entry after PRG low, including an already-blown fuse
    prog(2'b10, 4'b1100, 2'b11, PROG_CYCLES, 1'b1);
    drive_idle();
    step(1);
    rd_check(2'b10, 2'b11);

    // Illegal drive: BL not one-hot while PRG is high
    PRG = 1'b1; BL = 2'b11; PL = 4'b1111; WLP = 2'b01; WLN = '0;
    step(PROG_CYCLES + 1);
    drive_idle();
    step(2);
`ifdef OTP_MODEL_PROTOCOL_CHECK_EN
    check("perr_set", {31'd0, protocol_err}, 1);
    step(3);
    check("perr_sticky", {31'd0, protocol_err}, 1);
    rd_check(2'b01, 2'b10);
    rd_check(2'b10, 2'b11);
    reset = 1'b1;
    step(1);
    check("perr_cleared", {31'd0, protocol_err}, 0);
    reset = 1'b0;
    step(1);
`else
    check("perr_tied_low", {31'd0, protocol_err}, 0);
    rd_check(2'b01, 2'b10);
    rd_check(2'b10, 2'b11);
`endif

    step(3);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
